nios_system_mult_unit: RTL and testbench
========================================

NIOS_SYSTEM_MULT_UNIT -- requirements
Module: nios_system_mult_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (legal 8..64, even).
REQ-002 SHALL have parameter PIPE_STAGES, default 2, issue-to-result latency in cycles (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair presented.
REQ-006 SHALL have port in_ready  output  1  unit accepts operands this cycle.
REQ-007 SHALL have port in_src1  input  DATA_W  multiplicand.
REQ-008 SHALL have port in_src2  input  DATA_W  multiplier.
REQ-009 SHALL have port in_op  input  2  00 MUL (low word), 01 MULXUU, 10 MULXSU, 11 MULXSS (high words).
REQ-010 SHALL have port flush  input  1  synchronous kill of all in-flight operations.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_result  output  DATA_W  selected product word.

Function
REQ-014 SHALL accept an operation on a cycle where in_valid & in_ready are both 1.
REQ-015 SHALL compute the full 2*DATA_W product per op: MULXUU both unsigned; MULXSU src1 signed, src2 unsigned; MULXSS both signed; MUL low word (signedness irrelevant).
REQ-016 SHALL output bits [DATA_W-1:0] for MUL and bits [2*DATA_W-1:DATA_W] for MULX* ops.
REQ-017 SHALL hold a valid bit, op and partial data per stage in a PIPE_STAGES-deep pipeline.
REQ-018 SHALL advance all stages together when adv = ~out_valid | out_ready; otherwise all stages hold.
REQ-019 SHALL drive in_ready = adv, combinationally, with no dependence on in_valid.
REQ-020 SHALL present a result exactly PIPE_STAGES cycles after acceptance when adv stays 1.
REQ-021 SHALL keep out_result and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL deliver results in acceptance order; no drops or duplicates; internal bubbles are not compressed.
REQ-023 SHALL sustain one accepted operation per cycle when out_ready is held 1.
REQ-024 SHALL clear all stage valid bits, out_valid included, on the cycle after flush=1; an operand offered with flush=1 is discarded; flush=1 forces in_ready=1.
REQ-025 SHALL drive out_result to 0 whenever out_valid=0.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, clear all stage valid bits and data registers; out_valid=0, out_result=0, in_ready=1 in the following cycle.
REQ-027 SHALL discard in-flight operations when reset asserts mid-operation, with no result emitted afterwards.
REQ-028 SHALL give reset priority over flush and over acceptance.

Configuration
REQ-029 SHALL, with macro NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN defined, implement all four in_op encodings per REQ-015/016.
REQ-030 SHALL, without NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN, ignore in_op, always return the low word, and build only a DATA_W x DATA_W low-half multiplier; in_op port remains present.

Verification (DATA_W=32, PIPE_STAGES=2, macro defined unless stated)
REQ-031 SHALL test: src1=0x00010000, src2=0x00010000, op=00 then op=01, out_ready=1 -> 0x00000000 at cycle+2, then 0x00000001 at cycle+3.
REQ-032 SHALL test: src1=src2=0xFFFFFFFF, ops 00/01/10/11 back-to-back -> 0x00000001, 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on consecutive cycles.
REQ-033 SHALL test: 3 ops issued with out_ready=0 for 4 cycles -> in_ready falls to 0 once out_valid=1, first result held stable; after out_ready=1, all 3 results arrive in order.
REQ-034 SHALL test: 2 ops in flight, flush=1 for one cycle -> out_valid=0 next cycle, no stale result appears; the next op returns normally after 2 cycles.
REQ-035 SHALL test: reset=1 one cycle after acceptance -> out_valid never asserts for that op; out_result=0, in_ready=1.
REQ-036 SHALL test, macro undefined: src1=src2=0xFFFFFFFF, op=11 -> 0x00000001.

Source files
------------

// File: rtl/nios_system_mult_unit.sv
// rtl/nios_system_mult_unit.sv - pipelined multiply unit; NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN enables MULX high-word ops
module nios_system_mult_unit #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

`ifdef NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN
  localparam int PROD_W = 2 * DATA_W;
`else
  localparam int PROD_W = DATA_W;
`endif

  logic              w_adv;
  logic [PROD_W-1:0] w_prod;
  logic              r_valid [PIPE_STAGES];
  logic [PROD_W-1:0] r_prod  [PIPE_STAGES];

`ifdef NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN
  logic [1:0]        r_op    [PIPE_STAGES];
  logic              w_src1_signed;
  logic              w_src2_signed;
  logic [PROD_W-1:0] w_src1_ext;
  logic [PROD_W-1:0] w_src2_ext;

  // Signedness only changes the upper word, so the low word of any op is the MUL result.
  assign w_src1_signed = in_op[1];
  assign w_src2_signed = in_op[1] & in_op[0];
  assign w_src1_ext    = {{DATA_W{w_src1_signed & in_src1[DATA_W-1]}}, in_src1};
  assign w_src2_ext    = {{DATA_W{w_src2_signed & in_src2[DATA_W-1]}}, in_src2};
  // A 2W x 2W product truncated to 2W bits is the exact signed/unsigned 2W-bit result.
  assign w_prod        = w_src1_ext * w_src2_ext;
`else
  logic              w_unused_op;

  // Only the low half is ever returned, so op decoding is dropped entirely.
  assign w_unused_op = ^in_op;
  assign w_prod      = in_src1 * in_src2;
`endif

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign w_adv     = ~r_valid[PIPE_STAGES-1] | out_ready;
  assign in_ready  = w_adv | flush;
  assign out_valid = r_valid[PIPE_STAGES-1];

  // Stage registers: load stage 0 from the multiplier, shift the rest, flush kills valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_valid[i] <= 1'b0;
        r_prod[i]  <= '0;
`ifdef NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN
        r_op[i]    <= 2'b00;
`endif
      end
    end else begin
      if (w_adv) begin
        r_valid[0] <= in_valid & ~flush;
        r_prod[0]  <= w_prod;
`ifdef NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN
        r_op[0]    <= in_op;
`endif
        for (int i = 1; i < PIPE_STAGES; i++) begin
          r_valid[i] <= r_valid[i-1];
          r_prod[i]  <= r_prod[i-1];
`ifdef NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN
          r_op[i]    <= r_op[i-1];
`endif
        end
      end
      if (flush) begin
        for (int i = 0; i < PIPE_STAGES; i++) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Word select at the last stage; result forced to zero while nothing is valid.
  always_comb begin
    out_result = '0;
    if (r_valid[PIPE_STAGES-1]) begin
`ifdef NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN
      if (r_op[PIPE_STAGES-1] == 2'b00) begin
        out_result = r_prod[PIPE_STAGES-1][DATA_W-1:0];
      end else begin
        out_result = r_prod[PIPE_STAGES-1][PROD_W-1:DATA_W];
      end
`else
      out_result = r_prod[PIPE_STAGES-1];
`endif
    end
  end

endmodule

// File: tb/tb_nios_system_mult_unit.sv
// tb/tb_nios_system_mult_unit.sv - scoreboard bench for nios_system_mult_unit
module tb_nios_system_mult_unit;
  localparam int DATA_W = 32;
  localparam int PIPE   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [1:0]        in_op;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;

  always #5 clk = ~clk;

  nios_system_mult_unit #(.DATA_W(DATA_W), .PIPE_STAGES(PIPE)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_op      (in_op),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  typedef struct {
    logic [DATA_W-1:0] word;
    int                due;
  } exp_t;

  int                checks = 0;
  int                errors = 0;
  int                cyc    = 0;
  logic [DATA_W-1:0] exp_word;
  logic              exp_lat;
  exp_t              sb[$];
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every output handshake; push on every acceptance.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      if (prev_hold) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_result", {32'd0, out_result}, {32'd0, prev_res});
      end
      if (!out_valid) check("idle_result_zero", {32'd0, out_result}, 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h expected no result", out_result);
        end else begin
          e = sb.pop_front();
          check("result", {32'd0, out_result}, {32'd0, e.word});
          if (e.due >= 0) check("latency", 64'(cyc), 64'(e.due));
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_res  = out_result;
    end else begin
      prev_hold = 1'b0;
    end
    if (in_valid && in_ready && !flush && !reset) begin
      e.word = exp_word;
      e.due  = exp_lat ? cyc + PIPE : -1;
      sb.push_back(e);
    end
    if (flush || reset) sb.delete();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] hw, input logic [31:0] lw, input logic lat);
    bit ok;
    in_src1  = a;
    in_src2  = b;
    in_op    = op;
    in_valid = 1'b1;
    exp_lat  = lat;
`ifdef NIOS_SYSTEM_MULT_UNIT_HIGH_WORD_EN
    exp_word = hw;
`else
    exp_word = lw;
`endif
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_src1   = '0;
    in_src2   = '0;
    in_op     = 2'b00;
    exp_word  = '0;
    exp_lat   = 1'b0;
    step();
    step();
    @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_result", {32'd0, out_result}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    reset = 1'b0;

    // Low word then unsigned high word of 2^32.
    issue(32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000, 32'h0000_0000, 1'b1);
    issue(32'h0001_0000, 32'h0001_0000, 2'b01, 32'h0000_0001, 32'h0000_0000, 1'b1);
    idle(4);

    // All ones under every op, back-to-back, plus assorted vectors.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 32'h0000_0001, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 32'h0000_0001, 1'b1);
    issue(32'h1234_5678, 32'h0000_0003, 2'b00, 32'h369D_0368, 32'h369D_0368, 1'b1);
    issue(32'h0000_FFFF, 32'h0000_FFFF, 2'b00, 32'hFFFE_0001, 32'hFFFE_0001, 1'b1);
    issue(32'h8000_0000, 32'h0000_0002, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    issue(32'h8000_0000, 32'h0000_0002, 2'b01, 32'h0000_0001, 32'h0000_0000, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000, 32'h0000_0000, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 2'b10, 32'hC000_0000, 32'h0000_0000, 1'b1);
    idle(4);

    // Backpressure: three ops with out_ready low for four cycles.
    out_ready = 1'b0;
    fork
      begin
        issue(32'd7, 32'd6, 2'b00, 32'h0000_002A, 32'h0000_002A, 1'b0);
        issue(32'hFFFF_FFFF, 32'd2, 2'b01, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        issue(32'h10, 32'h10, 2'b00, 32'h0000_0100, 32'h0000_0100, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(5);

    // Flush with two ops in flight; the operand offered alongside flush is dropped.
    issue(32'd3, 32'd5, 2'b00, 32'd15, 32'd15, 1'b1);
    issue(32'd6, 32'd7, 2'b00, 32'd42, 32'd42, 1'b1);
    out_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_src1   = 32'h55;
    in_src2   = 32'd2;
    in_op     = 2'b00;
    exp_word  = 32'hAA;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    end
    step();
    issue(32'd9, 32'd9, 2'b00, 32'h51, 32'h51, 1'b1);
    idle(4);

    // Reset one cycle after acceptance, with a competing operand offered.
    issue(32'd4, 32'd4, 2'b00, 32'd16, 32'd16, 1'b1);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_src1  = 32'd2;
    in_src2  = 32'd2;
    exp_word = 32'd4;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_result", {32'd0, out_result}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    end

    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
